seq_mul: RTL and testbench
==========================

# seq_mul

Parametrised sequential shift-add unsigned multiplier, successor to the fixed 4-bit serial multiplier. Generalised to `WIDTH`-bit operands with a start/ready/done handshake, an asynchronous active-low reset and optional early termination. Intended as the shared multiply engine for datapaths that can tolerate multi-cycle latency in exchange for one adder of width `2*WIDTH`.

## Interface
Parameters:
- `WIDTH`, default 4: operand width in bits, at least 2; product is `2*WIDTH` bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `start` in 1: request; sampled only while `ready`=1.
- `x` in WIDTH: multiplier, unsigned; sampled on the accepting edge only.
- `y` in WIDTH: multiplicand, unsigned; sampled on the accepting edge only.
- `ready` out 1: engine idle, can accept `start`.
- `busy` out 1: operation in progress; always `~ready`.
- `done` out 1: one-cycle pulse, `p` is updated and valid.
- `p` out 2*WIDTH: product; held until the next `done`.

## Operation
- Internal registers:
  - `mcand`: 2*WIDTH bits.
  - `mplier`: WIDTH bits.
  - `acc`: 2*WIDTH bits.
  - `cnt`: $clog2(WIDTH+1) bits.
- States: IDLE, RUN.
- IDLE:
  - `ready`=1.
  - On `start`: `mcand`←zero-extended `y`, `mplier`←`x`, `acc`←0, `cnt`←0, go to RUN.
- RUN, each edge:
  - If `mplier[0]`, add `mcand` to the running sum.
  - `mcand`←`mcand`<<1, `mplier`←`mplier`>>1, `cnt`←`cnt`+1.
- Finish:
  - Condition: edge where `cnt`=WIDTH-1.
  - `p`←final sum, including that edge's addition.
  - `done`←1, state←IDLE.
- Arithmetic:
  - Product of two WIDTH-bit unsigned values always fits in 2*WIDTH bits; there is no overflow and no carry out.
  - Adder is 2*WIDTH wide.
- `start` while busy: ignored. Operands and the result are unaffected and no error is flagged.
- Back-to-back operation:
  - `ready` returns to 1 in the same cycle `done` is high.
  - A `start` in that cycle is accepted.
  - Throughput is one result per WIDTH+1 cycles (fixed mode).
- Reset (any time, including mid-RUN):
  - Immediately forces IDLE, `ready`=1, `busy`=0, `done`=0, `p`=0.
  - Internal registers are cleared.
  - The interrupted operation produces no `done`.

## Timing
- Reset values: `ready`=1, `busy`=0, `done`=0, `p`=0.
- Capture edge E0 (start accepted). RUN edges are E1..EWIDTH.
- Fixed mode:
  - `done`=1 and the new `p` are visible in the cycle following EWIDTH.
  - Latency is WIDTH cycles after E0, independent of operands.
- `done` is high for exactly one cycle.
- `p` changes only on a finishing edge or on reset.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `SEQ_MUL_EARLY_EXIT_EN`.
- Defined:
  - On any RUN edge where `mplier`==0 before the shift, finish immediately: `p`←`acc` with no add, `done`←1, go to IDLE.
  - The fixed `cnt`=WIDTH-1 finish still applies.
  - Latency = min(msb_index(x)+2, WIDTH) cycles after E0; x=0 gives latency 1.
- Undefined: latency is always WIDTH; the zero check logic is absent.
- Results are identical in both builds; only the `done` timing differs.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles, then release → `p`=0, `ready`=1, `busy`=0, `done`=0. Repeat with `reset_n` asserted mid-RUN → same values, no `done` pulse; the next operation, x=3 y=3, gives `p`=9.
- WIDTH=4, x=13, y=11 → `p`=143. `done` arrives exactly 4 cycles after E0, both builds (msb index 3).
- WIDTH=4, x=15, y=15 → `p`=225. `start` with x=3, y=5 in the `done` cycle is accepted → `p`=15 four cycles later (fixed build).
- Busy-ignore: start x=6, y=7; pulse `start` with x=9, y=9 at E2 → single `done`, `p`=42, `ready` low until `done`.
- Early exit:
  - x=0, y=9 → `p`=0; latency 1 with the macro, 4 without.
  - x=2, y=7 → `p`=14; latency 3 with the macro, 4 without.
- WIDTH=8 instance:
  - x=255, y=255 → `p`=65025, latency 8.
  - Plus 1000 random operand pairs, each checked against x*y, including random `start` while busy.

Source files
------------

// File: rtl/seq_mul.sv
// ============================================================================
//  Module      : seq_mul
//  Description : Sequential shift-add unsigned multiplier with a
//                start/ready/done handshake. One 2*WIDTH-bit adder is reused
//                over WIDTH cycles per product.
//                Optional early termination when the remaining multiplier
//                bits are all zero: define SEQ_MUL_EARLY_EXIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int              C_CW   = $clog2(WIDTH + 1);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [C_CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   p_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  // Running sum including this cycle's partial product (if the LSB is set).
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Control FSM and datapath; every output is a register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, y};
            mplier_q <= x;
            acc_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef SEQ_MUL_EARLY_EXIT_EN
          // No multiplier bits left: the accumulator already holds the product.
          if (mplier_q == '0) begin
            p_q     <= acc_q;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else
`endif
          begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + C_CW'(1);
            if (cnt_q == C_LAST) begin
              p_q     <= acc_d;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign p     = p_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_mul.sv
// ============================================================================
//  Module      : tb_seq_mul
//  Description : Scoreboard bench for seq_mul, WIDTH=4 and WIDTH=8 instances.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mul;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct {
    logic [15:0] p;
    int          lat;
    int          e0;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s4 = 1'b0, s8 = 1'b0;
  logic [3:0]  x4 = '0, y4 = '0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic        r4, b4, d4, r8, b8, d8;
  logic [7:0]  p4;
  logic [15:0] p8;

  exp_t q4[$];
  exp_t q8[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  seq_mul #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(s4), .x(x4), .y(y4),
    .ready(r4), .busy(b4), .done(d4), .p(p4)
  );

  seq_mul #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(s8), .x(x8), .y(y8),
    .ready(r8), .busy(b8), .done(d8), .p(p8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard monitors: one per instance, compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && d4 === 1'b1) begin
      if (q4.size() == 0) fail_now("unexpected_done_w4");
      else begin
        e = q4.pop_front();
        chk("p_w4", {24'd0, p4}, {16'd0, e.p});
        if (e.lat >= 0) chk("latency_w4", cyc - e.e0, e.lat);
        chk("ready_at_done_w4", {31'd0, r4}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && d8 === 1'b1) begin
      if (q8.size() == 0) fail_now("unexpected_done_w8");
      else begin
        e = q8.pop_front();
        chk("p_w8", {16'd0, p8}, {16'd0, e.p});
        if (e.lat >= 0) chk("latency_w8", cyc - e.e0, e.lat);
        chk("busy_at_done_w8", {31'd0, b8}, 32'd0);
      end
    end
  end

  task automatic issue4(input logic [3:0] xa, input logic [3:0] ya,
                        input logic [15:0] ep, input int lat, input bit push);
    int k = 0;
    @(negedge clk);
    while (r4 !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) fail_now("ready_timeout_w4");
    s4 = 1'b1; x4 = xa; y4 = ya;
    @(posedge clk); #1;
    s4 = 1'b0;
    if (push) q4.push_back('{ep, lat, cyc});
  endtask

  task automatic issue8(input logic [7:0] xa, input logic [7:0] ya,
                        input logic [15:0] ep, input int lat);
    int k = 0;
    @(negedge clk);
    while (r8 !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) fail_now("ready_timeout_w8");
    s8 = 1'b1; x8 = xa; y8 = ya;
    @(posedge clk); #1;
    s8 = 1'b0;
    q8.push_back('{ep, lat, cyc});
  endtask

  task automatic drain(input string name);
    int k = 0;
    @(negedge clk);
    while ((q4.size() != 0 || q8.size() != 0 || r4 !== 1'b1 || r8 !== 1'b1) && k < 100) begin
      @(negedge clk); k++;
    end
    if (k >= 100) fail_now(name);
  endtask

  initial begin
    int k;
    logic [7:0] rx, ry;

    // Power-on reset held for 3 cycles.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("rst_p",     {24'd0, p4}, 32'd0);
    chk("rst_ready", {31'd0, r4}, 32'd1);
    chk("rst_busy",  {31'd0, b4}, 32'd0);
    chk("rst_done",  {31'd0, d4}, 32'd0);
    chk("rst_p_w8",  {16'd0, p8}, 32'd0);

    // Basic product.
    issue4(4'd13, 4'd11, 16'd143, 4, 1'b1);
    drain("drain_basic");

    // Reset in the middle of an operation: no done for it afterwards.
    issue4(4'd7, 4'd5, 16'd35, 4, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_p",     {24'd0, p4}, 32'd0);
    chk("midrst_ready", {31'd0, r4}, 32'd1);
    chk("midrst_busy",  {31'd0, b4}, 32'd0);
    chk("midrst_done",  {31'd0, d4}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (6) @(negedge clk);
    issue4(4'd3, 4'd3, 16'd9, EE ? 3 : 4, 1'b1);
    drain("drain_midrst");

    // Back-to-back: start asserted in the done cycle is accepted.
    issue4(4'd15, 4'd15, 16'd225, 4, 1'b1);
    k = 0;
    while (d4 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) fail_now("done_timeout_b2b");
    chk("b2b_ready_in_done", {31'd0, r4}, 32'd1);
    s4 = 1'b1; x4 = 4'd3; y4 = 4'd5;
    @(posedge clk); #1;
    s4 = 1'b0;
    q4.push_back('{16'd15, EE ? 3 : 4, cyc});
    drain("drain_b2b");

    // Start while busy is ignored.
    issue4(4'd6, 4'd7, 16'd42, 4, 1'b1);
    @(posedge clk); #1;
    s4 = 1'b1; x4 = 4'd9; y4 = 4'd9;
    chk("busy_at_e2",  {31'd0, b4}, 32'd1);
    chk("ready_at_e2", {31'd0, r4}, 32'd0);
    @(posedge clk); #1;
    s4 = 1'b0;
    chk("ready_low_e3", {31'd0, r4}, 32'd0);
    drain("drain_busy");

    // Early-exit corner operands.
    issue4(4'd0, 4'd9, 16'd0,  EE ? 1 : 4, 1'b1);
    drain("drain_x0");
    issue4(4'd2, 4'd7, 16'd14, EE ? 3 : 4, 1'b1);
    drain("drain_x2");

    // WIDTH=8 maximum operands.
    issue8(8'd255, 8'd255, 16'd65025, 8);
    drain("drain_w8max");

    // WIDTH=8 random operands, with stray start pulses while busy.
    for (int i = 0; i < 1000; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      issue8(rx, ry, 16'(rx) * 16'(ry), -1);
      if ($urandom_range(0, 1) == 1) begin
        s8 = 1'b1;
        x8 = 8'($urandom_range(0, 255));
        y8 = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        s8 = 1'b0;
      end
    end
    drain("drain_random");

    chk("q4_empty", q4.size(), 32'd0);
    chk("q8_empty", q8.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
